// File: rtl/program_loader.sv
// program_loader: boot-time loader between the UART receiver and the memories.
// Assembles a little-endian byte stream into 32-bit words. The stream holds an
// instruction count N, N instruction words, a data count M and M data words.
// Instruction words go to instruction RAM. Data words go to data RAM over the
// I/O port. On success it sends status byte 0xAA and raises core_start. On a
// bad count or a skid overflow it sends 0xEE once and raises load_error.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   rx_data, rx_valid        received byte and its one-cycle strobe
//   tx_ready                 UART transmitter can take a byte
//   data_ready_io            data-RAM write complete
//   tx_data, tx_valid        status byte, held until tx_ready
//   wr_en_instr, addr_in_instr, data_in_instr   instruction RAM write port
//   memwrite_io, memread_io, addr_io, write_data_io   data RAM I/O port
//   core_start, load_error   sticky completion / error flags
module program_loader #(
    parameter int unsigned IMEM_WORDS = 16384,
    parameter int unsigned DMEM_WORDS = 4096
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    input  logic        tx_ready,
    input  logic        data_ready_io,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    output logic        wr_en_instr,
    output logic [31:0] addr_in_instr,
    output logic [31:0] data_in_instr,
    output logic        memwrite_io,
    output logic        memread_io,
    output logic [31:0] addr_io,
    output logic [31:0] write_data_io,
    output logic        core_start,
    output logic        load_error
);

    typedef enum logic [2:0] {
        StIcnt, StIword, StDcnt, StDword, StDwait, StAck, StRun, StErr
    } state_e;

    state_e      state_q;
    logic [1:0]  idx_q;
    logic [31:0] shift_q;
    logic [31:0] cnt_n_q, cnt_m_q;
    logic [31:0] i_q, j_q;
    logic        skid_valid_q;
    logic [7:0]  skid_q;

    logic [7:0]  tx_data_q;
    logic        tx_valid_q;
    logic        wr_en_q;
    logic [31:0] addr_instr_q, data_instr_q;
    logic        memwrite_q;
    logic [31:0] addr_io_q, wdata_io_q;
    logic        core_start_q, load_error_q;

    // Byte presented to the assembler this cycle; the skid entry takes priority.
    logic        byte_valid;
    logic [7:0]  byte_data;
    logic [31:0] word_full;
    logic        last_byte;

    always_comb begin
        byte_valid = 1'b0;
        byte_data  = rx_data;
        case (state_q)
            StIcnt, StIword, StDcnt: byte_valid = rx_valid;
            StDword: begin
                if (skid_valid_q) begin
                    byte_valid = 1'b1;
                    byte_data  = skid_q;
                end else begin
                    byte_valid = rx_valid;
                end
            end
            default: byte_valid = 1'b0;
        endcase
    end

    assign word_full = {byte_data, shift_q[31:8]};
    assign last_byte = byte_valid && (idx_q == 2'd3);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StIcnt;
            idx_q        <= 2'd0;
            shift_q      <= 32'd0;
            cnt_n_q      <= 32'd0;
            cnt_m_q      <= 32'd0;
            i_q          <= 32'd0;
            j_q          <= 32'd0;
            skid_valid_q <= 1'b0;
            skid_q       <= 8'd0;
            tx_data_q    <= 8'd0;
            tx_valid_q   <= 1'b0;
            wr_en_q      <= 1'b0;
            addr_instr_q <= 32'd0;
            data_instr_q <= 32'd0;
            memwrite_q   <= 1'b0;
            addr_io_q    <= 32'd0;
            wdata_io_q   <= 32'd0;
            core_start_q <= 1'b0;
            load_error_q <= 1'b0;
        end else begin
            wr_en_q <= 1'b0;

            // The index wraps to 0 on the 4th byte, which is also the only byte
            // that can cause a state change while assembling.
            if (byte_valid) begin
                shift_q <= word_full;
                idx_q   <= idx_q + 2'd1;
            end

            // Skid entry: refilled by a byte arriving while the held one is used.
            if (state_q == StDword && skid_valid_q) begin
                if (rx_valid) begin
                    skid_q <= rx_data;
                end else begin
                    skid_valid_q <= 1'b0;
                end
            end else if (state_q == StDwait && rx_valid && !skid_valid_q) begin
                skid_q       <= rx_data;
                skid_valid_q <= 1'b1;
            end

            case (state_q)
                StIcnt: begin
                    if (last_byte) begin
                        cnt_n_q <= word_full;
                        if (word_full > 32'(IMEM_WORDS)) begin
                            state_q      <= StErr;
                            load_error_q <= 1'b1;
                            tx_valid_q   <= 1'b1;
                            tx_data_q    <= 8'hEE;
                        end else if (word_full == 32'd0) begin
                            state_q <= StDcnt;
                        end else begin
                            state_q <= StIword;
                        end
                    end
                end
                StIword: begin
                    if (last_byte) begin
                        wr_en_q      <= 1'b1;
                        addr_instr_q <= {i_q[29:0], 2'b00};
                        data_instr_q <= word_full;
                        i_q          <= i_q + 32'd1;
                        if (i_q + 32'd1 == cnt_n_q) begin
                            state_q <= StDcnt;
                        end
                    end
                end
                StDcnt: begin
                    if (last_byte) begin
                        cnt_m_q <= word_full;
                        if (word_full > 32'(DMEM_WORDS)) begin
                            state_q      <= StErr;
                            load_error_q <= 1'b1;
                            tx_valid_q   <= 1'b1;
                            tx_data_q    <= 8'hEE;
                        end else if (word_full == 32'd0) begin
                            state_q    <= StAck;
                            tx_valid_q <= 1'b1;
                            tx_data_q  <= 8'hAA;
                        end else begin
                            state_q <= StDword;
                        end
                    end
                end
                StDword: begin
                    if (last_byte) begin
                        wdata_io_q <= word_full;
                        addr_io_q  <= {j_q[29:0], 2'b00};
                        memwrite_q <= 1'b1;
                        state_q    <= StDwait;
                    end
                end
                StDwait: begin
                    if (rx_valid && skid_valid_q) begin
                        // Second byte during one write: the stream outran the RAM.
                        state_q      <= StErr;
                        memwrite_q   <= 1'b0;
                        load_error_q <= 1'b1;
                        tx_valid_q   <= 1'b1;
                        tx_data_q    <= 8'hEE;
                    end else if (data_ready_io) begin
                        memwrite_q <= 1'b0;
                        j_q        <= j_q + 32'd1;
                        idx_q      <= 2'd0;
                        if (j_q + 32'd1 == cnt_m_q) begin
                            state_q    <= StAck;
                            tx_valid_q <= 1'b1;
                            tx_data_q  <= 8'hAA;
                        end else begin
                            state_q <= StDword;
                        end
                    end
                end
                StAck: begin
                    if (tx_ready) begin
                        tx_valid_q   <= 1'b0;
                        core_start_q <= 1'b1;
                        state_q      <= StRun;
                    end
                end
                StErr: begin
                    // tx_valid is only set on entry, so 0xEE goes out exactly once.
                    if (tx_valid_q && tx_ready) begin
                        tx_valid_q <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign tx_data       = tx_data_q;
    assign tx_valid      = tx_valid_q;
    assign wr_en_instr   = wr_en_q;
    assign addr_in_instr = addr_instr_q;
    assign data_in_instr = data_instr_q;
    assign memwrite_io   = memwrite_q;
    assign memread_io    = 1'b0;
    assign addr_io       = addr_io_q;
    assign write_data_io = wdata_io_q;
    assign core_start    = core_start_q;
    assign load_error    = load_error_q;

endmodule

// File: tb/tb_program_loader.sv
// Directed testbench for program_loader. Inputs change 1 ns after the rising
// edge; a monitor samples outputs on the falling edge to log write pulses,
// data-RAM writes and completed status-byte handshakes.
module tb_program_loader;

    logic        clk;
    logic        rst;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        tx_ready;
    logic        data_ready_io;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        wr_en_instr;
    logic [31:0] addr_in_instr;
    logic [31:0] data_in_instr;
    logic        memwrite_io;
    logic        memread_io;
    logic [31:0] addr_io;
    logic [31:0] write_data_io;
    logic        core_start;
    logic        load_error;

    program_loader dut (
        .clk           (clk),
        .rst           (rst),
        .rx_data       (rx_data),
        .rx_valid      (rx_valid),
        .tx_ready      (tx_ready),
        .data_ready_io (data_ready_io),
        .tx_data       (tx_data),
        .tx_valid      (tx_valid),
        .wr_en_instr   (wr_en_instr),
        .addr_in_instr (addr_in_instr),
        .data_in_instr (data_in_instr),
        .memwrite_io   (memwrite_io),
        .memread_io    (memread_io),
        .addr_io       (addr_io),
        .write_data_io (write_data_io),
        .core_start    (core_start),
        .load_error    (load_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Monitor logs
    logic [31:0] wr_addr [32];
    logic [31:0] wr_data [32];
    int          wr_cnt = 0;
    logic [31:0] mw_addr [32];
    logic [31:0] mw_data [32];
    int          mw_cnt = 0;
    int          mw_cycles = 0;
    logic        mw_prev = 1'b0;
    logic [7:0]  tx_byte [32];
    int          tx_cnt = 0;

    always @(negedge clk) begin
        if (wr_en_instr && wr_cnt < 32) begin
            wr_addr[wr_cnt] <= addr_in_instr;
            wr_data[wr_cnt] <= data_in_instr;
            wr_cnt          <= wr_cnt + 1;
        end
        if (memwrite_io) begin
            mw_cycles <= mw_cycles + 1;
        end
        if (memwrite_io && !mw_prev && mw_cnt < 32) begin
            mw_addr[mw_cnt] <= addr_io;
            mw_data[mw_cnt] <= write_data_io;
            mw_cnt          <= mw_cnt + 1;
        end
        mw_prev <= memwrite_io;
        if (tx_valid && tx_ready && tx_cnt < 32) begin
            tx_byte[tx_cnt] <= tx_data;
            tx_cnt          <= tx_cnt + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic put(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        step();
        rx_valid = 1'b0;
    endtask

    task automatic put_word(input logic [31:0] w);
        put(w[7:0]);
        put(w[15:8]);
        put(w[23:16]);
        put(w[31:24]);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();
    endtask

    int wr_base, mw_base, mwc_base, tx_base;

    task automatic mark();
        wr_base  = wr_cnt;
        mw_base  = mw_cnt;
        mwc_base = mw_cycles;
        tx_base  = tx_cnt;
    endtask

    initial begin
        rst           = 1'b1;
        rx_data       = 8'd0;
        rx_valid      = 1'b0;
        tx_ready      = 1'b0;
        data_ready_io = 1'b0;
        step();
        step();
        rst = 1'b0;
        step();

        // Reset state
        check("rst_tx_valid", 32'(tx_valid), 32'd0);
        check("rst_tx_data", 32'(tx_data), 32'd0);
        check("rst_wr_en", 32'(wr_en_instr), 32'd0);
        check("rst_addr_instr", addr_in_instr, 32'd0);
        check("rst_memwrite", 32'(memwrite_io), 32'd0);
        check("rst_memread", 32'(memread_io), 32'd0);
        check("rst_addr_io", addr_io, 32'd0);
        check("rst_core_start", 32'(core_start), 32'd0);
        check("rst_load_error", 32'(load_error), 32'd0);

        // Two instruction words, no data, ACK held off for 10 cycles
        mark();
        put_word(32'd2);
        put_word(32'h11223344);
        check("i0_wr_en", 32'(wr_en_instr), 32'd1);
        check("i0_addr", addr_in_instr, 32'd0);
        check("i0_data", data_in_instr, 32'h11223344);
        put_word(32'hAABBCCDD);
        check("i1_wr_en", 32'(wr_en_instr), 32'd1);
        check("i1_addr", addr_in_instr, 32'd4);
        check("i1_data", data_in_instr, 32'hAABBCCDD);
        put_word(32'd0);
        check("i_wr_pulses", wr_cnt - wr_base, 32'd2);
        check("ack_tx_valid", 32'(tx_valid), 32'd1);
        check("ack_tx_data", 32'(tx_data), 32'hAA);
        for (int k = 0; k < 10; k++) begin
            step();
            check("ack_hold_valid", 32'(tx_valid), 32'd1);
            check("ack_hold_data", 32'(tx_data), 32'hAA);
            check("ack_hold_core", 32'(core_start), 32'd0);
        end
        tx_ready = 1'b1;
        step();
        tx_ready = 1'b0;
        check("ack_core_start", 32'(core_start), 32'd1);
        check("ack_tx_drop", 32'(tx_valid), 32'd0);
        step();
        check("ack_tx_count", tx_cnt - tx_base, 32'd1);
        check("ack_tx_byte", 32'(tx_byte[tx_base]), 32'hAA);
        put_word(32'h12345678);
        step();
        check("run_ignores", wr_cnt - wr_base, 32'd2);
        check("run_core_sticky", 32'(core_start), 32'd1);

        // One data word with a 4-cycle write
        do_reset();
        check("rst2_core_start", 32'(core_start), 32'd0);
        mark();
        put_word(32'd0);
        put_word(32'd1);
        put_word(32'hDEADBEEF);
        check("d0_memwrite", 32'(memwrite_io), 32'd1);
        check("d0_addr", addr_io, 32'd0);
        check("d0_data", write_data_io, 32'hDEADBEEF);
        step();
        step();
        step();
        check("d0_still_high", 32'(memwrite_io), 32'd1);
        data_ready_io = 1'b1;
        step();
        data_ready_io = 1'b0;
        check("d0_memwrite_fall", 32'(memwrite_io), 32'd0);
        check("d0_ack_valid", 32'(tx_valid), 32'd1);
        check("d0_ack_data", 32'(tx_data), 32'hAA);
        check("d0_mw_cycles", mw_cycles - mwc_base, 32'd4);
        tx_ready = 1'b1;
        step();
        tx_ready = 1'b0;
        check("d0_core_start", 32'(core_start), 32'd1);
        check("d0_no_error", 32'(load_error), 32'd0);

        // Back-to-back data bytes, one byte absorbed by the skid entry
        do_reset();
        mark();
        put_word(32'd0);
        put_word(32'd2);
        put_word(32'h01020304);
        data_ready_io = 1'b1;
        put(8'h0D);
        data_ready_io = 1'b0;
        put(8'hF0);
        put(8'hFE);
        put(8'hCA);
        step();
        check("sk_memwrite", 32'(memwrite_io), 32'd1);
        check("sk_addr", addr_io, 32'd4);
        check("sk_data", write_data_io, 32'hCAFEF00D);
        data_ready_io = 1'b1;
        step();
        data_ready_io = 1'b0;
        step();
        check("sk_w0_addr", mw_addr[mw_base], 32'd0);
        check("sk_w0_data", mw_data[mw_base], 32'h01020304);
        check("sk_mw_cycles", mw_cycles - mwc_base, 32'd2);
        check("sk_ack_data", 32'(tx_data), 32'hAA);
        check("sk_no_error", 32'(load_error), 32'd0);
        tx_ready = 1'b1;
        step();
        tx_ready = 1'b0;
        check("sk_core_start", 32'(core_start), 32'd1);

        // Skid overflow: write takes 2 cycles while bytes keep coming
        do_reset();
        mark();
        put_word(32'd0);
        put_word(32'd2);
        put_word(32'h01020304);
        put(8'h0D);
        data_ready_io = 1'b1;
        put(8'hF0);
        data_ready_io = 1'b0;
        check("ov_load_error", 32'(load_error), 32'd1);
        check("ov_tx_valid", 32'(tx_valid), 32'd1);
        check("ov_tx_data", 32'(tx_data), 32'hEE);
        check("ov_memwrite", 32'(memwrite_io), 32'd0);
        put(8'hFE);
        put(8'hCA);
        tx_ready = 1'b1;
        step();
        step();
        step();
        tx_ready = 1'b0;
        check("ov_tx_drop", 32'(tx_valid), 32'd0);
        check("ov_tx_count", tx_cnt - tx_base, 32'd1);
        check("ov_core_start", 32'(core_start), 32'd0);

        // Instruction count one above capacity
        do_reset();
        mark();
        put_word(32'd16385);
        check("big_load_error", 32'(load_error), 32'd1);
        check("big_tx_data", 32'(tx_data), 32'hEE);
        put_word(32'h11111111);
        put_word(32'h22222222);
        tx_ready = 1'b1;
        step();
        step();
        step();
        tx_ready = 1'b0;
        check("big_no_wr", wr_cnt - wr_base, 32'd0);
        check("big_tx_count", tx_cnt - tx_base, 32'd1);
        check("big_tx_byte", 32'(tx_byte[tx_base]), 32'hEE);
        check("big_core_start", 32'(core_start), 32'd0);

        // Reset during the third instruction word, then a full valid load
        do_reset();
        put_word(32'd4);
        put_word(32'hA0A0A0A0);
        put_word(32'hB1B1B1B1);
        put(8'h01);
        put(8'h02);
        rst = 1'b1;
        #1;
        check("mid_rst_addr", addr_in_instr, 32'd0);
        check("mid_rst_data", data_in_instr, 32'd0);
        check("mid_rst_wr_en", 32'(wr_en_instr), 32'd0);
        step();
        rst = 1'b0;
        step();
        mark();
        put_word(32'd1);
        put_word(32'h55667788);
        check("re_wr_addr", addr_in_instr, 32'd0);
        check("re_wr_data", data_in_instr, 32'h55667788);
        put_word(32'd1);
        put_word(32'h99AABBCC);
        check("re_addr_io", addr_io, 32'd0);
        check("re_data_io", write_data_io, 32'h99AABBCC);
        data_ready_io = 1'b1;
        step();
        data_ready_io = 1'b0;
        check("re_ack_data", 32'(tx_data), 32'hAA);
        tx_ready = 1'b1;
        step();
        tx_ready = 1'b0;
        check("re_core_start", 32'(core_start), 32'd1);
        check("re_wr_pulses", wr_cnt - wr_base, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
